// File: rtl/output_channel_buffer_pkg.sv
// Shared interconnect types and constants for the TIA channel buffers.
// The packet type and the depth/threshold defaults live here so every PE agrees.
package output_channel_buffer_pkg;

  typedef logic [7:0] packet_t;

  localparam int TIA_CHANNEL_BUFFER_FIFO_DEPTH = 4;
  localparam int TIA_LINK_STALL_THRESHOLD      = 64;

endpackage

// File: rtl/output_channel_buffer_if.sv
// PE-to-buffer enqueue port and buffer-to-buffer link handshake.
// The sender drives data and req; the receiver drives back-pressure/ack.
interface output_channel_if
  import output_channel_buffer_pkg::*;
#(
  parameter int DEPTH = TIA_CHANNEL_BUFFER_FIFO_DEPTH
) ();
  packet_t                  packet;
  logic                     enqueue;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;

  modport sender   (output packet, output enqueue, input  full, input  count);
  modport receiver (input  packet, input  enqueue, output full, output count);
endinterface

interface link_if
  import output_channel_buffer_pkg::*;
();
  logic    req;
  packet_t packet;
  logic    ack;

  modport sender   (output req, output packet, input  ack);
  modport receiver (input  req, input  packet, output ack);
endinterface

// File: rtl/output_channel_buffer.sv
// Send-side packet FIFO of a TIA PE: drives one outgoing link, reports
// quiescence and flags a link that stays back-pressured too long.
module output_channel_buffer
  import output_channel_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH      = TIA_CHANNEL_BUFFER_FIFO_DEPTH,
  parameter int STALL_THRESHOLD = TIA_LINK_STALL_THRESHOLD
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  output_channel_if.receiver        output_channel,
  link_if.sender                    link,
  output logic                      quiescent,
  output logic                      stalled
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [15:0]   THRESHOLD_C = 16'(STALL_THRESHOLD);

  packet_t fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   stall_q, stall_d;

  logic full, req, accept, xfer;

  always_comb begin
    full    = (count_q == DEPTH_C);
    req     = enable && (count_q != '0);
    // full is judged on the pre-edge count, so a same-edge transfer never frees a slot
    accept  = enable && output_channel.enqueue && !full;
    xfer    = enable && req && link.ack;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;

    if (xfer)   head_d = head_q + PW'(1);
    if (accept) tail_d = tail_q + PW'(1);

    if (accept && !xfer)      count_d = count_q + CW'(1);
    else if (xfer && !accept) count_d = count_q - CW'(1);

    if (enable) begin
      if (req && !link.ack)
        stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
      else
        stall_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Storage carries no reset; pointers alone define which slots are live.
  always_ff @(posedge clock) begin
    if (accept) fifo_mem[tail_q] <= output_channel.packet;
  end

  assign link.req             = req;
  assign link.packet          = fifo_mem[head_q];
  assign output_channel.full  = full;
  assign output_channel.count = count_q;
  assign quiescent            = (count_q == '0);
  assign stalled              = (stall_q >= THRESHOLD_C);

endmodule

// File: doc/output_channel_buffer.md
# output_channel_buffer

Per-channel FIFO on the send side of a TIA processing element. The PE's output port enqueues packets into it, and it drives one outgoing `link_if` toward the downstream input channel buffer. It also reports quiescence and flags a link that has been back-pressured for too long.

## Interface
- `FIFO_DEPTH`, default `TIA_CHANNEL_BUFFER_FIFO_DEPTH`: number of packet slots; power of two, ≥ 2.
- `STALL_THRESHOLD`, default 64: consecutive blocked cycles before `stalled` asserts; 1 ≤ value < 2^16.

- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: active high; when low, no state changes and no link transfer.
- `output_channel`  `output_channel_if.receiver`: PE side.
  - `packet` (`packet_t`), in.
  - `enqueue`, in.
  - `full`, out.
  - `count`, out, `$clog2(FIFO_DEPTH)+1` bits.
- `link`  `link_if.sender`: link side.
  - `req`, out.
  - `packet` (`packet_t`), out.
  - `ack`, in.
- `quiescent`  out  1: FIFO empty.
- `stalled`  out  1: `req` high with `ack` low for ≥ `STALL_THRESHOLD` consecutive enabled cycles.

## Operation
- **State**
  - `head` and `tail` pointers, `$clog2(FIFO_DEPTH)` bits each; they wrap naturally modulo `FIFO_DEPTH`.
  - `count`, `$clog2(FIFO_DEPTH)+1` bits.
  - `stall_count`, 16 bits, saturating.
- **Combinational outputs**
  - `link.packet = fifo[head]`.
  - `link.req = enable && (count != 0)`.
  - `output_channel.full = (count == FIFO_DEPTH)`.
  - `output_channel.count = count`.
  - `quiescent = (count == 0)`.
  - `stalled = (stall_count >= STALL_THRESHOLD)`.
- **Transfer** occurs on an edge where `enable && link.req && link.ack`. It advances `head`.
- **Enqueue** is accepted on an edge where `enable && enqueue && !full`. It writes `fifo[tail]` and advances `tail`.
- **Count update**
  - +1 on accept only.
  - −1 on transfer only.
  - Unchanged on both or neither.
- **Boundary rules**
  - Enqueue while full is silently dropped. This holds even if a transfer occurs on the same edge, because `full` is judged on the pre-edge count.
  - Enqueue and transfer on the same edge with count = 1 is legal. The old head leaves, the new packet becomes head, and count stays 1.
  - Empty: `req` is low, so a transfer is impossible. `link.packet` is don't-care.
  - `enable` low: `req` forced low, enqueue ignored, `stall_count` held.
- **Stall counter**, evaluated each enabled edge:
  - If `link.req && !link.ack`, increment and saturate at 0xFFFF.
  - Otherwise clear to 0.
- **Reset** (asynchronous assert, at any time including mid-transfer):
  - Immediately clears `head`, `tail`, `count` and `stall_count`.
  - FIFO storage is not reset.
  - Outputs during reset: `req=0`, `full=0`, `count=0`, `quiescent=1`, `stalled=0`.
  - Deassertion is synchronised externally; the first active edge after release may enqueue.

## Timing
- **Enqueue to link**: a packet enqueued at edge N into an empty FIFO drives `link.req`/`link.packet` after edge N. The earliest transfer is at edge N+1.
- **Throughput**: sustained 1 packet/cycle with continuous enqueue and continuous `ack`.
- **Handshake**
  - `ack` is level-sensitive and sampled at the edge; no registered acknowledge.
  - `req` may drop only after a transfer empties the FIFO or `enable` falls.
  - `link.packet` is stable while `req` is high and no transfer has occurred.
- **Full flag**: `full` reflects the registered count, so it deasserts one cycle after a transfer from full.
- **Stalled flag**: `stalled` asserts after the edge on which `stall_count` reaches the threshold. It clears after the first edge without a stall.

## Structure
- `packet_t` and `TIA_CHANNEL_BUFFER_FIFO_DEPTH` come from the interconnect package, `interconnect.svh`.
- `output_channel_if` is added alongside `input_channel_if` in the same package. Its modports are `sender` (PE) and `receiver` (buffer).
- Add a new shared constant `TIA_LINK_STALL_THRESHOLD` and use it as the default when instantiated in the PE.
- Single module, no sub-module; the stall monitor is roughly 15 lines inline.

## Test plan
- **Reset**: assert `reset=0` mid-stream with count 3 → immediately `count=0`, `req=0`, `quiescent=1`, `stalled=0`. After release, enqueue 0xA1 → `req=1` with packet 0xA1 next cycle.
- **Fill/drop**
  - Stimulus: depth 4, `ack=0`; enqueue 0x10..0x14.
  - Response: `full=1` after the 4th. 0x14 is dropped.
  - Then raise `ack` for 4 cycles: the link delivers 0x10, 0x11, 0x12, 0x13, then `req=0`.
- **Simultaneous**: count=1 holding 0x20; enqueue 0x21 with `ack=1` → 0x20 transferred, count stays 1, `link.packet=0x21`.
- **Full plus transfer**: count=4 with `ack=1`, enqueue 0x30 on the same edge → 0x30 dropped, count=3.
- **Wrap**: stream 20 packets through depth 4 at 1/cycle with `ack` held high → order preserved, no drop, count never exceeds 1.
- **Stall/enable**
  - Stimulus: `STALL_THRESHOLD=8`, count=1, `ack=0`.
  - `stalled` rises after the 8th edge.
  - Drop `enable` for 5 cycles → `req=0`, `stall_count` held.
  - Raise `ack` with `enable=1` → transfer, `stalled=0` next cycle.
